// File: rtl/msg_pkg.sv
// Shared message-path definitions: tag encodings, default burst lengths, router state.
// Pure definitions; no latency or flow control involved.
package msg_pkg;
    localparam int XB_SIZE_DEF     = 32;
    localparam int APP_DATA_WIDTH  = 256;

    localparam int MSG_TAG_PIXEL   = 0;
    localparam int MSG_TAG_DRAM    = 1;

    localparam int BURST_LEN_PIXEL = 1;
    // One DRAM message carries two app-width beats worth of bus words.
    localparam int BURST_LEN_DRAM  = 2 * APP_DATA_WIDTH / XB_SIZE_DEF;

    typedef enum logic [1:0] {
        RTR_IDLE  = 2'd0,
        RTR_BURST = 2'd1,
        RTR_ERROR = 2'd2
    } rtr_state_t;
endpackage

// File: rtl/msg_burst_tracker.sv
// Message framing: tracks header/burst/error state and picks the target channel.
// tgt is combinational from state and the head tag; state advances one edge after ack.
module msg_burst_tracker
    import msg_pkg::*;
#(
    parameter int                    N_CH       = 2,
    parameter int                    TAG_W      = 2,
    parameter int                    LEN_W      = 6,
    parameter logic [N_CH*LEN_W-1:0] BURST_LENS = {6'd16, 6'd1}
) (
    input  logic             bus_clk,
    input  logic             reset,
    input  logic             msg_vld,
    input  logic [TAG_W-1:0] tag,
    input  logic             ack,
    output logic [TAG_W-1:0] tgt,
    output logic             tgt_ok,
    output logic             in_burst,
    output logic             error
);
    rtr_state_t       state;
    logic [TAG_W-1:0] lock;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] hdr_len;

    assign tgt    = (state == RTR_BURST) ? lock : tag;
    assign tgt_ok = 32'(tgt) < N_CH;

    // A zero length field is treated as a single-word message.
    always_comb begin
        hdr_len = LEN_W'(1);
        for (int c = 0; c < N_CH; c++) begin
            if (TAG_W'(c) == tag && BURST_LENS[c*LEN_W +: LEN_W] != '0)
                hdr_len = BURST_LENS[c*LEN_W +: LEN_W];
        end
    end

    always_ff @(posedge bus_clk or posedge reset) begin
        if (reset) begin
            state     <= RTR_IDLE;
            lock      <= '0;
            remaining <= '0;
            in_burst  <= 1'b0;
            error     <= 1'b0;
        end else begin
            case (state)
                RTR_IDLE: begin
                    if (ack) begin
                        if (hdr_len > LEN_W'(1)) begin
                            lock      <= tag;
                            remaining <= hdr_len - LEN_W'(1);
                            state     <= RTR_BURST;
                            in_burst  <= 1'b1;
                        end
                    end else if (msg_vld && !tgt_ok) begin
                        state <= RTR_ERROR;
                        error <= 1'b1;
                    end
                end
                RTR_BURST: begin
                    if (ack) begin
                        if (remaining == LEN_W'(1)) begin
                            remaining <= '0;
                            state     <= RTR_IDLE;
                            in_burst  <= 1'b0;
                        end else begin
                            remaining <= remaining - LEN_W'(1);
                        end
                    end
                end
                default: begin
                    state    <= RTR_ERROR;
                    in_burst <= 1'b0;
                    error    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: rtl/pc_msg_router.sv
// Steers PC message words into per-channel FIFOs; ack is combinational, write/data 1 cycle later.
// Stalls while the target channel's almost_full is high, even mid-burst; other channels never stall it.
module pc_msg_router
    import msg_pkg::*;
#(
    parameter int                    XB_SIZE    = XB_SIZE_DEF,
    parameter int                    N_CH       = 2,
    parameter int                    TAG_W      = 2,
    parameter int                    LEN_W      = 6,
    parameter logic [N_CH*LEN_W-1:0] BURST_LENS = {6'(BURST_LEN_DRAM), 6'(BURST_LEN_PIXEL)},
    parameter int                    CNT_W      = 16
) (
    input  logic                  bus_clk,
    input  logic                  reset,
    input  logic                  pc_msg_empty,
    output logic                  pc_msg_ack,
    input  logic [XB_SIZE-1:0]    pc_msg,
    input  logic [N_CH-1:0]       ch_full,
    output logic [N_CH-1:0]       ch_wren,
    output logic [XB_SIZE-1:0]    ch_data,
    output logic                  in_burst,
    output logic                  error,
    output logic [N_CH*CNT_W-1:0] ch_word_cnt
);
    logic [TAG_W-1:0] tgt;
    logic             tgt_ok;
    logic             full_sel;
    logic [CNT_W-1:0] cnt [N_CH];

    msg_burst_tracker #(
        .N_CH       (N_CH),
        .TAG_W      (TAG_W),
        .LEN_W      (LEN_W),
        .BURST_LENS (BURST_LENS)
    ) u_tracker (
        .bus_clk  (bus_clk),
        .reset    (reset),
        .msg_vld  (!pc_msg_empty),
        .tag      (pc_msg[TAG_W-1:0]),
        .ack      (pc_msg_ack),
        .tgt      (tgt),
        .tgt_ok   (tgt_ok),
        .in_burst (in_burst),
        .error    (error)
    );

    always_comb begin
        full_sel = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            if (TAG_W'(c) == tgt)
                full_sel = ch_full[c];
        end
    end

    assign pc_msg_ack = !pc_msg_empty && !error && tgt_ok && !full_sel;

    always_ff @(posedge bus_clk or posedge reset) begin
        if (reset) begin
            ch_wren <= '0;
            ch_data <= '0;
            for (int c = 0; c < N_CH; c++)
                cnt[c] <= '0;
        end else begin
            ch_wren <= '0;
            if (pc_msg_ack) begin
                ch_data <= pc_msg;
                for (int c = 0; c < N_CH; c++) begin
                    if (TAG_W'(c) == tgt) begin
                        ch_wren[c] <= 1'b1;
                        cnt[c]     <= cnt[c] + CNT_W'(1);
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_cnt
        assign ch_word_cnt[g*CNT_W +: CNT_W] = cnt[g];
    end
endmodule

// File: tb/tb_pc_msg_router.sv
// Drives a default two-channel router and a four-channel, 4-bit-counter router against a
// message-level model: words are framed by header tag and per-channel burst length.
module tb_pc_msg_router;
    int total = 0;
    int bad   = 0;

    logic bus_clk = 1'b0;
    logic reset   = 1'b1;
    always #5 bus_clk = ~bus_clk;

    logic        empty_a, ack_a, inb_a, err_a;
    logic [31:0] msg_a, data_a, cnt_a;
    logic [1:0]  full_a, wren_a;

    logic        empty_b, ack_b, inb_b, err_b;
    logic [31:0] msg_b, data_b;
    logic [3:0]  full_b, wren_b;
    logic [15:0] cnt_b;

    pc_msg_router dut_a (
        .bus_clk(bus_clk), .reset(reset), .pc_msg_empty(empty_a), .pc_msg_ack(ack_a),
        .pc_msg(msg_a), .ch_full(full_a), .ch_wren(wren_a), .ch_data(data_a),
        .in_burst(inb_a), .error(err_a), .ch_word_cnt(cnt_a)
    );

    pc_msg_router #(
        .N_CH(4), .TAG_W(2), .LEN_W(6),
        .BURST_LENS({6'd2, 6'd4, 6'd16, 6'd1}), .CNT_W(4)
    ) dut_b (
        .bus_clk(bus_clk), .reset(reset), .pc_msg_empty(empty_b), .pc_msg_ack(ack_b),
        .pc_msg(msg_b), .ch_full(full_b), .ch_wren(wren_b), .ch_data(data_b),
        .in_burst(inb_b), .error(err_b), .ch_word_cnt(cnt_b)
    );

    // Model state: message framing and expected registered outputs.
    bit          sel;
    int          nch;
    int          lens [4];
    int          cmask;
    int          left;
    int          lock;
    bit          err_m;
    int          cnt_m [4];
    logic [3:0]  exp_wren;
    logic [31:0] exp_data;
    bit   [31:0] inq [$];
    bit          hole;
    logic [3:0]  full_v;
    logic        cur_e;
    logic [31:0] cur_w;

    function automatic logic [3:0] o_wren();
        return sel ? wren_b : {2'b00, wren_a};
    endfunction
    function automatic logic [31:0] o_data();
        return sel ? data_b : data_a;
    endfunction
    function automatic logic o_ack();
        return sel ? ack_b : ack_a;
    endfunction
    function automatic logic o_inb();
        return sel ? inb_b : inb_a;
    endfunction
    function automatic logic o_err();
        return sel ? err_b : err_a;
    endfunction
    function automatic logic [31:0] o_cnt(input int c);
        return sel ? 32'(cnt_b[c*4 +: 4]) : 32'(cnt_a[c*16 +: 16]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs();
        chk("wren", 32'(o_wren()), 32'(exp_wren));
        chk("data", o_data(), exp_data);
        chk("in_burst", 32'(o_inb()), 32'(left > 0));
        chk("error", 32'(o_err()), 32'(err_m));
        for (int c = 0; c < nch; c++)
            chk($sformatf("cnt%0d", c), o_cnt(c), 32'(cnt_m[c]));
    endtask

    task automatic drive();
        cur_e = (inq.size() == 0) || hole;
        cur_w = (inq.size() != 0) ? inq[0] : $urandom;
        if (sel) begin
            empty_b = cur_e; msg_b = cur_w; full_b = full_v;
            empty_a = 1'b1;  msg_a = '0;    full_a = '0;
        end else begin
            empty_a = cur_e; msg_a = cur_w; full_a = full_v[1:0];
            empty_b = 1'b1;  msg_b = '0;    full_b = '0;
        end
    endtask

    // One cycle, entered and left at the falling edge.
    task automatic step();
        logic expa;
        int   dst;
        check_outs();
        drive();
        #1;
        expa = 1'b0;
        dst  = 0;
        if (!cur_e && !err_m) begin
            dst = (left > 0) ? lock : int'(cur_w[1:0]);
            if (dst >= nch) err_m = 1'b1;
            else            expa  = !full_v[dst];
        end
        chk("ack", 32'(o_ack()), 32'(expa));
        if (expa) begin
            exp_wren   = 4'(1 << dst);
            exp_data   = cur_w;
            cnt_m[dst] = (cnt_m[dst] + 1) & cmask;
            if (left == 0) begin
                left = ((lens[dst] < 1) ? 1 : lens[dst]) - 1;
                lock = dst;
            end else begin
                left--;
            end
        end else begin
            exp_wren = '0;
        end
        @(posedge bus_clk);
        if (expa) void'(inq.pop_front());
        @(negedge bus_clk);
    endtask

    // Asynchronous reset from mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        #1;
        reset = 1'b1;
        #1;
        left = 0; lock = 0; err_m = 1'b0;
        foreach (cnt_m[c]) cnt_m[c] = 0;
        exp_wren = '0; exp_data = '0;
        inq.delete();
        check_outs();
        @(negedge bus_clk);
        reset = 1'b0;
    endtask

    task automatic push_msg(input int tag);
        bit [31:0] w;
        w = $urandom;
        w[1:0] = 2'(tag);
        inq.push_back(w);
        for (int i = 1; i < lens[tag]; i++) inq.push_back($urandom);
    endtask

    initial begin
        bit [31:0] w;
        sel = 1'b0; nch = 2; lens = '{1, 16, 0, 0}; cmask = 32'hFFFF;
        full_v = '0; hole = 1'b0;
        drive();
        @(negedge bus_clk);
        do_reset();

        // Pixel singles
        inq.push_back(32'h100); inq.push_back(32'h104); inq.push_back(32'h108);
        repeat (5) step();
        chk("pix_cnt0", o_cnt(0), 32'd3);

        // DRAM burst with tag-free body, then a pixel word right behind it
        w = $urandom; w[1:0] = 2'd1; inq.push_back(w);
        for (int i = 0; i < 15; i++) begin
            w = $urandom; w[1:0] = 2'd0; inq.push_back(w);
        end
        inq.push_back(32'h200);
        repeat (19) step();
        chk("dram_cnt1", o_cnt(1), 32'd16);
        chk("dram_cnt0", o_cnt(0), 32'd4);

        // Backpressure on ch1 mid-burst; ch0 fullness must not stall the burst
        push_msg(1);
        repeat (5) step();
        full_v = 4'b0010;
        repeat (10) step();
        chk("bp_cnt1_stalled", o_cnt(1), 32'd21);
        full_v = 4'b0001;
        repeat (13) step();
        full_v = '0;
        chk("bp_cnt1", o_cnt(1), 32'd32);

        // Reset mid-burst; next word is a header again
        push_msg(1);
        repeat (7) step();
        do_reset();
        inq.push_back(32'h300);
        repeat (3) step();
        chk("post_rst_cnt0", o_cnt(0), 32'd1);
        chk("post_rst_cnt1", o_cnt(1), 32'd0);

        // Unknown tag is terminal and blocks later valid words
        inq.push_back(32'h3); inq.push_back(32'h400);
        repeat (4) step();
        chk("err_sticky", 32'(err_a), 32'd1);
        do_reset();

        // Random traffic on the default router
        for (int k = 0; k < 250; k++) begin
            if (inq.size() < 8) push_msg($urandom_range(0, 1));
            hole   = ($urandom_range(0, 3) == 0);
            full_v = {2'b00, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0)};
            step();
        end

        // Four-channel router, 4-bit wrapping counters
        sel = 1'b1; nch = 4; lens = '{1, 16, 4, 2}; cmask = 15;
        full_v = '0; hole = 1'b0;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            if (inq.size() < 8) push_msg($urandom_range(0, 3));
            hole = ($urandom_range(0, 4) == 0);
            for (int c = 0; c < 4; c++) full_v[c] = ($urandom_range(0, 3) == 0);
            step();
        end
        full_v = '0; hole = 1'b0;
        for (int k = 0; k < 200 && inq.size() > 0; k++) step();
        step();
        chk("drain_left", 32'(inq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
